// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader states and program framing constants
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, CLR, RUN, HALTED, ERR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [5:0] HLT_OPCODE = 6'b111111;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word shifter with a registered word-ready pulse
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  idx,
  output logic [31:0] word,
  output logic        word_rdy
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        rdy_q, rdy_d;
  always_comb begin
    idx_d  = clr ? 2'd0 : idx_q + 2'(valid);
    word_d = clr ? '0 : valid ? {word_q[23:0], byte_in} : word_q;
    rdy_d  = !clr && valid && idx_q == 2'(BYTES_PER_WORD - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      rdy_q  <= rdy_d;
    end
  end
  assign idx      = idx_q;
  assign word     = word_q;
  assign word_rdy = rdy_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed program into instruction memory, then runs the core
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              hlt,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              pc_clr,
  output logic              core_run,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err
);
  localparam int CW = ADDR_W + 1;
  state_t        state_q, state_d;
  logic [15:0]   n_q, n_d, n_new;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          xfer, go, last, too_long;
  logic [1:0]    idx;
  logic [31:0]   word;
  always_comb begin
    s_ready  = state_q inside {HDR0, HDR1, LOAD};
    xfer     = s_valid && s_ready;
    go       = start && (state_q inside {IDLE, HALTED, ERR});
    n_new    = {n_q[15:8], s_data};
    too_long = 32'(n_new) > (32'd1 << ADDR_W);
    last     = idx == 2'(BYTES_PER_WORD - 1) && 32'(cnt_q) + 32'd1 == 32'(n_q);
    state_d  = state_q;
    n_d      = n_q;
    err_d    = go ? 1'b0 : err_q;
    cnt_d    = go ? '0 : cnt_q + CW'(imem_we);
    case (state_q)
      IDLE, HALTED, ERR: state_d = go ? HDR0 : state_q;
      HDR0: if (xfer) begin
        n_d[15:8] = s_data;
        state_d   = HDR1;
      end
      HDR1: if (xfer) begin
        n_d     = n_new;
        err_d   = too_long;
        state_d = n_new == '0 ? CLR : too_long ? ERR : LOAD;
      end
      LOAD: state_d = xfer && last ? CLR : LOAD;
      CLR:  state_d = RUN;
      RUN:  state_d = hlt ? HALTED : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (go),
    .valid    (xfer && state_q == LOAD),
    .byte_in  (s_data),
    .idx      (idx),
    .word     (word),
    .word_rdy (imem_we)
  );
  assign imem_addr  = cnt_q[ADDR_W-1:0];
  assign imem_wdata = WORD_W'(word);
  assign pc_clr     = state_q == CLR;
  assign core_run   = state_q == RUN;
  assign word_cnt   = cnt_q;
  assign err        = err_q;
endmodule
